// File: rtl/div_pkg.sv
// Shared definitions for the pipelined non-restoring divider: the div-by-zero quotient
// constant and the bit layout of the per-stage payload vector.
package div_pkg;

    // Payload layout, LSB first: valid | rem[W:0] | quo[W-1:0] | dvs[W-1:0] | div_zero | tag
    localparam int PL_VALID   = 0;
    localparam int PL_REM_LSB = 1;

    function automatic int pl_quo_lsb(input int width);
        return width + 2;
    endfunction

    function automatic int pl_dvs_lsb(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int pl_dz_bit(input int width);
        return 3 * width + 2;
    endfunction

    function automatic int pl_tag_lsb(input int width);
        return 3 * width + 3;
    endfunction

    function automatic int pl_width(input int width, input int tag_w);
        return 3 * width + 3 + tag_w;
    endfunction

    function automatic logic [63:0] DIV_ZERO_Q(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/div_nr_stage.sv
// One divider pipeline stage: BITS_PER_STAGE unrolled non-restoring iterations feeding a
// payload register that loads only on adv.
module div_nr_stage
    import div_pkg::*;
#(
    parameter int WIDTH          = 13,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_W          = 4,
    localparam int PW            = pl_width(WIDTH, TAG_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [PW-1:0] src,
    output logic [PW-1:0] dst
);

    localparam int QUO_LSB = pl_quo_lsb(WIDTH);
    localparam int DVS_LSB = pl_dvs_lsb(WIDTH);

    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem_v;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] quo_v;
    logic [PW-1:0]    dst_next;

    assign dvs = src[DVS_LSB +: WIDTH];

    // The quo field starts out holding the dividend; its MSBs are shifted into the
    // remainder while quotient bits fill in from the bottom.
    always_comb begin
        rem_v   = src[PL_REM_LSB +: WIDTH+1];
        quo_v   = src[QUO_LSB +: WIDTH];
        shifted = '0;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            shifted = {rem_v[WIDTH-1:0], quo_v[WIDTH-1]};
            rem_v   = rem_v[WIDTH] ? shifted + {1'b0, dvs} : shifted - {1'b0, dvs};
            quo_v   = {quo_v[WIDTH-2:0], ~rem_v[WIDTH]};
        end
        dst_next                        = src;
        dst_next[PL_REM_LSB +: WIDTH+1] = rem_v;
        dst_next[QUO_LSB +: WIDTH]      = quo_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst <= '0;
        end else if (adv) begin
            dst <= dst_next;
        end
    end

endmodule

// File: rtl/pipe_divider_nr.sv
// Fully pipelined unsigned non-restoring divider: input register, S iteration stages and a
// correcting output register, all advancing together under a single valid/ready stall.
module pipe_divider_nr
    import div_pkg::*;
#(
    parameter int WIDTH          = 13,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int S       = WIDTH / BITS_PER_STAGE;
    localparam int PW      = pl_width(WIDTH, TAG_W);
    localparam int QUO_LSB = pl_quo_lsb(WIDTH);
    localparam int DVS_LSB = pl_dvs_lsb(WIDTH);
    localparam int DZ_BIT  = pl_dz_bit(WIDTH);
    localparam int TAG_LSB = pl_tag_lsb(WIDTH);

    logic          adv;
    logic [PW-1:0] in_next;
    logic [PW-1:0] in_reg;
    logic [PW-1:0] stage_pl [0:S];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        in_next                     = '0;
        in_next[PL_VALID]           = in_valid;
        in_next[QUO_LSB +: WIDTH]   = dividend;
        in_next[DVS_LSB +: WIDTH]   = divisor;
        in_next[DZ_BIT]             = (divisor == '0);
        in_next[TAG_LSB +: TAG_W]   = in_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg <= '0;
        end else if (adv) begin
            in_reg <= in_next;
        end
    end

    assign stage_pl[0] = in_reg;

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_stage
            div_nr_stage #(
                .WIDTH          (WIDTH),
                .BITS_PER_STAGE (BITS_PER_STAGE),
                .TAG_W          (TAG_W)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .adv (adv),
                .src (stage_pl[gi]),
                .dst (stage_pl[gi+1])
            );
        end
    endgenerate

    logic [PW-1:0]    fin;
    logic [WIDTH-1:0] fin_dvs;
    logic [WIDTH:0]   fin_rem;
    logic [WIDTH-1:0] fixed_rem;

    assign fin     = stage_pl[S];
    assign fin_dvs = fin[DVS_LSB +: WIDTH];
    assign fin_rem = fin[PL_REM_LSB +: WIDTH+1];

    // True remainder lies in [0, divisor), so WIDTH-bit wraparound of the add-back is exact.
    assign fixed_rem = fin_rem[WIDTH-1:0] + (fin_rem[WIDTH] ? fin_dvs : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= fin[PL_VALID];
            div_zero  <= fin[DZ_BIT];
            out_tag   <= fin[TAG_LSB +: TAG_W];
            // With a zero divisor every iteration only shifts, leaving the dividend as remainder.
            remainder <= fixed_rem;
            if (fin[DZ_BIT]) begin
                quotient <= WIDTH'(DIV_ZERO_Q(WIDTH));
            end else begin
                quotient <= fin[QUO_LSB +: WIDTH];
            end
        end
    end

endmodule
